fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Parametrised successor to the single-instruction front end. Generates fetch addresses, issues FW-wide block requests to instruction memory with up to OUTST requests in flight, and buffers returned instructions in a DEPTH-entry queue. Presents one instruction per cycle to the decoder over a valid/ready handshake. Supports redirect from the branch/jalr resolution path, discarding stale responses, and halts fetch after an access fault.

Parameters:
FW, 2, instructions per fetch block (1, 2 or 4); block size is FW*4 bytes.
DEPTH, 8, instruction buffer entries (power of 2, >= 2*FW).
OUTST, 2, maximum in-flight imem requests (1..4).
PC_W, 64, address width.
RESET_PC, 64'h80000000, fetch PC after reset; must be 4-byte aligned.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
imem_req_valid  out  1  block request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  PC_W  block base address, aligned to FW*4
imem_rsp_valid  in  1  response valid; responses return in order; no backpressure
imem_rsp_data  in  FW*32  slot i holds instruction at base+4*i
imem_rsp_err  in  1  access fault for whole block
redirect_valid  in  1  redirect fetch; flushes the buffer
redirect_pc  in  PC_W  redirect target; bits [1:0] ignored
dec_valid  out  1  buffer head valid
dec_ready  in  1  decoder accepts head
dec_instr  out  32  head instruction
dec_pc  out  PC_W  head PC
dec_fault  out  1  head came from a faulting block; dec_instr is 0

Behaviour:
- Reset (RST high at edge): pc=RESET_PC, buffer empty, inflight=0, drop_cnt=0, halted=0, offset FIFO empty. Outputs: imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0, dec_fault=0. imem_req_addr shows the aligned RESET_PC. RST mid-operation drops all in-flight responses; the environment resets imem together.
- imem_req_addr = pc with bits [log2(FW*4)-1:0] cleared. off = pc[log2(FW*4)-1:2].
- imem_req_valid = !halted && !redirect_valid && inflight<OUTST && (DEPTH - count) >= FW*(inflight+1). Uses registered count and does not credit a same-cycle dequeue.
- On request fire: push off into the offset FIFO (depth OUTST), pc <= imem_req_addr + FW*4, inflight++.
- Response: inflight--, pop the offset FIFO.
  - If drop_cnt>0: discard, drop_cnt--.
  - Otherwise enqueue slots off..FW-1 in ascending order, pc = base+4*i, fault = imem_rsp_err.
  - If err: enqueue exactly one entry (instr=0, fault=1, pc of first slot), then set halted=1.
  - Responses are never refused; the credit rule guarantees space.
- Simultaneous request fire and response in the same cycle: inflight unchanged.
- Redirect (redirect_valid=1), in the same edge:
  - buffer count <- 0;
  - pc <- {redirect_pc[PC_W-1:2],2'b0};
  - halted <- 0;
  - drop_cnt <- inflight after this cycle's response is accounted; a response arriving in the redirect cycle is itself discarded.
  - No request is issued that cycle.
  - A dec handshake completing in the redirect cycle counts as consumed.
  - The first block after a redirect may have nonzero off.
- Dequeue: dec_valid = count!=0; head advances on dec_valid&&dec_ready. Enqueue of up to FW entries and dequeue of 1 may occur in the same cycle. count ranges 0..DEPTH; read/write pointers wrap modulo DEPTH.
- Latency: request fire at cycle N, response at N+k, head visible at dec_valid in cycle N+k+1 if the buffer was empty.
- Full boundary: with count=DEPTH-FW+1 and inflight=0, no request issues until a dequeue.

Decomposition:
- Package fetch_pkg holds: INSTR_W=32; the log2 helpers for FW, DEPTH and OUTST; the ibuf entry layout {fault, pc, instr}; the redirect bundle layout.
- One natural sub-module, fetch_ibuf: circular buffer with DEPTH entries, multi-write (up to FW entries per cycle with start offset), single-read, synchronous flush, count output.
- Offset FIFO and counters stay in fetch_unit.

Test Plan:
- Reset, FW=2, imem 1-cycle latency, dec_ready=1 -> first req addr 0x80000000, then 0x80000008; dec_pc sequence 0x80000000, 0x80000004, 0x80000008, ... with no bubbles after fill.
- dec_ready=0 held, DEPTH=8, FW=2 -> exactly 4 blocks accepted; imem_req_valid stays 0 with count=8; one dequeue then leaves count=7, still no request until count<=6.
- Two requests in flight, redirect_pc=0x80001004 -> both responses discarded; next req addr 0x80001000; first dec_pc 0x80001004; buffer empty in the cycle after redirect.
- Redirect in the same cycle as a response and a dec handshake -> response dropped, handshake counted, drop_cnt equals the remaining inflight (check inflight=1 -> drop_cnt=1).
- imem_rsp_err on block 0x80000010 -> one entry with dec_fault=1, dec_instr=0, dec_pc=0x80000010; no further requests until redirect; after redirect, fetch resumes at redirect_pc.
- RST asserted with inflight=2 and count=5 -> next cycle dec_valid=0, imem_req_valid=0; restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and width helpers for the instruction fetch front end.
package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_MAX_W = 64;

    // Index width for an n-entry structure (at least one bit).
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width able to hold the values 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    typedef struct packed {
        logic                fault;
        logic [PC_MAX_W-1:0] pc;
        logic [INSTR_W-1:0]  instr;
    } ibuf_entry_t;

    typedef struct packed {
        logic                valid;
        logic [PC_MAX_W-1:0] pc;
    } redirect_t;

endpackage

// File: rtl/fetch_ibuf.sv
// Circular instruction buffer: up to FW writes per cycle starting at a slot
// offset, one read per cycle, synchronous flush.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int FW    = 2,
    localparam int AW   = idx_w(DEPTH),
    localparam int CW   = cnt_w(DEPTH),
    localparam int SW   = idx_w(FW),
    localparam int NW   = cnt_w(FW),
    localparam int EW   = $bits(ibuf_entry_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [SW-1:0]    wr_start,
    input  logic [NW-1:0]    wr_num,
    input  logic [FW*EW-1:0] wr_data,
    input  logic             rd_en,
    output ibuf_entry_t      rd_data,
    output logic [CW-1:0]    count
);

    ibuf_entry_t         mem [DEPTH];
    logic [AW-1:0]       wp;
    logic [AW-1:0]       rp;
    logic [FW*EW-1:0]    shifted;
    logic [NW-1:0]       add_n;

    // Drop the leading slots so the first kept entry sits at lane 0.
    assign shifted = wr_data >> (EW * int'(wr_start));
    assign add_n   = wr_en ? wr_num : '0;
    assign rd_data = (count != '0) ? mem[rp] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_en) begin
                for (int j = 0; j < FW; j++) begin
                    if (NW'(j) < wr_num) begin
                        mem[wp + AW'(j)] <= ibuf_entry_t'(shifted[j*EW +: EW]);
                    end
                end
                wp <= wp + AW'(wr_num);
            end
            if (rd_en) begin
                rp <= rp + AW'(1);
            end
            count <= count + CW'(add_n) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: issues block requests with bounded outstanding count,
// buffers returned instructions and hands them to the decoder one per cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              FW       = 2,
    parameter int              DEPTH    = 8,
    parameter int              OUTST    = 2,
    parameter int              PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h8000_0000)
) (
    input  logic               CLK,
    input  logic               RST,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [FW*32-1:0]   imem_rsp_data,
    input  logic               imem_rsp_err,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [31:0]        dec_instr,
    output logic [PC_W-1:0]    dec_pc,
    output logic               dec_fault
);

    localparam int BLK_B   = FW * 4;
    localparam int BLK_LSB = $clog2(BLK_B);
    localparam int OFF_W   = idx_w(FW);
    localparam int IF_W    = cnt_w(OUTST);
    localparam int QW      = idx_w(OUTST);
    localparam int CW      = cnt_w(DEPTH);
    localparam int NW      = cnt_w(FW);
    localparam int EW      = $bits(ibuf_entry_t);

    logic [PC_W-1:0]  pc;
    logic [IF_W-1:0]  inflight;
    logic [IF_W-1:0]  drop_cnt;
    logic             halted;

    // Offset FIFO keeps the word-aligned request pc; its low bits are the slot offset.
    logic [PC_W-1:0]  q_pc [OUTST];
    logic [QW-1:0]    q_wp;
    logic [QW-1:0]    q_rp;

    redirect_t        redir;
    logic             req_fire;
    logic             keep;
    logic [PC_W-1:0]  rsp_pc;
    logic [PC_W-1:0]  rsp_base;
    logic [OFF_W-1:0] rsp_off;
    logic [31:0]      free_slots;
    logic [31:0]      need_slots;
    logic [CW-1:0]    count;
    logic [OFF_W-1:0] wr_start;
    logic [NW-1:0]    wr_num;
    logic [FW*EW-1:0] wr_data;
    ibuf_entry_t      head;

    function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
        return (p == QW'(OUTST - 1)) ? '0 : p + QW'(1);
    endfunction

    assign redir = '{valid: redirect_valid, pc: PC_MAX_W'(redirect_pc & ~PC_W'(3))};

    // Both handshakes transfer on a cycle where valid and ready are high together;
    // a valid request is held stable until accepted, responses are never refused.
    assign imem_req_addr  = pc & ~PC_W'(BLK_B - 1);
    assign free_slots     = 32'(DEPTH) - 32'(count);
    assign need_slots     = 32'(FW) * (32'(inflight) + 32'd1);
    assign imem_req_valid = !RST && !halted && !redir.valid &&
                            (32'(inflight) < 32'(OUTST)) && (free_slots >= need_slots);
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_pc   = q_pc[q_rp];
    assign rsp_base = rsp_pc & ~PC_W'(BLK_B - 1);
    assign rsp_off  = OFF_W'(rsp_pc[BLK_LSB-1:0] >> 2);
    assign keep     = imem_rsp_valid && !redir.valid && (drop_cnt == '0);
    assign wr_start = imem_rsp_err ? '0 : rsp_off;
    assign wr_num   = imem_rsp_err ? NW'(1) : NW'(FW) - NW'(rsp_off);

    always_comb begin
        wr_data = '0;
        if (imem_rsp_err) begin
            wr_data[EW-1:0] = {1'b1, PC_MAX_W'(rsp_pc), INSTR_W'(0)};
        end else begin
            for (int i = 0; i < FW; i++) begin
                wr_data[i*EW +: EW] = {1'b0, PC_MAX_W'(rsp_base + PC_W'(4 * i)),
                                       imem_rsp_data[i*INSTR_W +: INSTR_W]};
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            halted   <= 1'b0;
            q_wp     <= '0;
            q_rp     <= '0;
        end else begin
            if (req_fire) begin
                q_pc[q_wp] <= pc;
                q_wp       <= q_next(q_wp);
            end
            if (imem_rsp_valid) begin
                q_rp <= q_next(q_rp);
            end
            inflight <= inflight + IF_W'(req_fire) - IF_W'(imem_rsp_valid);
            if (redir.valid) begin
                pc       <= redir.pc[PC_W-1:0];
                halted   <= 1'b0;
                drop_cnt <= inflight - IF_W'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc <= imem_req_addr + PC_W'(BLK_B);
                end
                if (imem_rsp_valid && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - IF_W'(1);
                end
                if (keep && imem_rsp_err) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    fetch_ibuf #(
        .DEPTH (DEPTH),
        .FW    (FW)
    ) u_ibuf (
        .clk      (CLK),
        .rst      (RST),
        .flush    (redir.valid),
        .wr_en    (keep),
        .wr_start (wr_start),
        .wr_num   (wr_num),
        .wr_data  (wr_data),
        .rd_en    (dec_valid && dec_ready),
        .rd_data  (head),
        .count    (count)
    );

    assign dec_valid = (count != '0);
    assign dec_instr = head.instr;
    assign dec_pc    = head.pc[PC_W-1:0];
    assign dec_fault = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a request/epoch-level reference model.
module tb_fetch_unit;

    localparam int          FW       = 2;
    localparam int          DEPTH    = 8;
    localparam int          OUTST    = 2;
    localparam int          PC_W     = 64;
    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam logic [63:0] BLK_MASK = ~64'(FW * 4 - 1);
    localparam int          EXP_W    = 97;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [PC_W-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [FW*32-1:0]  imem_rsp_data;
    logic              imem_rsp_err;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              dec_valid;
    logic              dec_ready;
    logic [31:0]       dec_instr;
    logic [PC_W-1:0]   dec_pc;
    logic              dec_fault;

    fetch_unit #(
        .FW       (FW),
        .DEPTH    (DEPTH),
        .OUTST    (OUTST),
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .CLK            (clk),
        .RST            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_fault      (dec_fault)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    typedef struct {
        logic [63:0] pc;
        int          epoch;
        int          due;
        logic        err;
    } req_t;

    req_t             pend_q[$];
    logic [EXP_W-1:0] exp_q[$];
    logic [63:0]      m_pc;
    int               epoch;
    logic             m_halted;
    int               cyc;

    int n_checks = 0;
    int n_errors = 0;
    int n_hs     = 0;
    int n_faults = 0;

    // stimulus knobs
    int          k_ready = 100;
    int          k_ack   = 100;
    int          k_redir = 0;
    int          k_err   = 0;
    int          k_lat   = 1;
    logic [63:0] err_blk = '1;
    logic        force_redir = 1'b0;
    logic [63:0] force_tgt = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9e37_79b1) ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_idle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        #1;
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_dec_instr", dec_instr, 0);
        chk("rst_dec_fault", dec_fault, 0);
        chk("rst_req_addr", imem_req_addr, RESET_PC & BLK_MASK);
        pend_q.delete();
        exp_q.delete();
        m_pc     = RESET_PC;
        m_halted = 1'b0;
        epoch++;
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model over the edge.
    task automatic step();
        logic  exp_valid;
        logic  fire;
        req_t  r;
        @(negedge clk);
        cyc++;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = '0;
        if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_err   = pend_q[0].err;
            for (int i = 0; i < FW; i++) begin
                imem_rsp_data[i*32 +: 32] = mem_word((pend_q[0].pc & BLK_MASK) + 64'(4 * i));
            end
        end
        redirect_valid = force_redir || (int'($urandom_range(0, 99)) < k_redir);
        redirect_pc    = force_redir ? force_tgt : 64'h8000_0000 + 64'($urandom_range(0, 4095));
        force_redir    = 1'b0;
        dec_ready      = int'($urandom_range(0, 99)) < k_ready;
        imem_req_ready = int'($urandom_range(0, 99)) < k_ack;
        #1;

        exp_valid = !m_halted && !redirect_valid && (pend_q.size() < OUTST) &&
                    ((DEPTH - exp_q.size()) >= FW * (pend_q.size() + 1));
        chk("req_valid", imem_req_valid, exp_valid);
        chk("dec_valid", dec_valid, exp_q.size() != 0);
        fire = exp_valid && imem_req_ready;
        if (fire) chk("req_addr", imem_req_addr, m_pc & BLK_MASK);

        if (exp_q.size() != 0 && dec_ready) begin
            chk("dec_pc", dec_pc, exp_q[0][95:32]);
            chk("dec_instr", dec_instr, exp_q[0][31:0]);
            chk("dec_fault", dec_fault, exp_q[0][96]);
            n_hs++;
            if (dec_fault) n_faults++;
            void'(exp_q.pop_front());
        end

        if (imem_rsp_valid) begin
            r = pend_q.pop_front();
            if (!redirect_valid && r.epoch == epoch) begin
                if (r.err) begin
                    exp_q.push_back({1'b1, r.pc, 32'h0});
                    m_halted = 1'b1;
                end else begin
                    for (logic [63:0] a = r.pc; a < (r.pc & BLK_MASK) + 64'(FW * 4); a += 64'd4)
                        exp_q.push_back({1'b0, a, mem_word(a)});
                end
            end
        end

        if (redirect_valid) begin
            exp_q.delete();
            epoch++;
            m_pc     = redirect_pc & ~64'd3;
            m_halted = 1'b0;
        end else if (fire) begin
            pend_q.push_back('{pc: m_pc, epoch: epoch,
                               due: cyc + int'($urandom_range(1, k_lat)),
                               err: (int'($urandom_range(0, 99)) < k_err) ||
                                    ((m_pc & BLK_MASK) == err_blk)});
            m_pc = (m_pc & BLK_MASK) + 64'(FW * 4);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        cyc      = 0;
        epoch    = 0;
        m_pc     = RESET_PC;
        m_halted = 1'b0;
        rst      = 1'b1;
        drive_idle();

        // streaming, 1-cycle memory, decoder always ready
        do_reset();
        run(30);

        // decoder stalled: buffer fills, single dequeue, stall again
        k_ready = 0;
        run(15);
        k_ready = 100;
        run(1);
        k_ready = 0;
        run(6);
        k_ready = 100;
        run(10);

        // redirect with two requests in flight
        do_reset();
        k_lat = 4;
        run(2);
        force_redir = 1'b1;
        force_tgt   = 64'h8000_1004;
        run(20);

        // access fault on block 0x80000010, then redirect
        do_reset();
        k_lat   = 1;
        err_blk = 64'h8000_0010;
        run(25);
        chk("fault_seen", n_faults, 1);
        err_blk     = '1;
        force_redir = 1'b1;
        force_tgt   = 64'h8000_0200;
        run(20);

        // random traffic, with reset landing mid-operation between chunks
        for (int c = 0; c < 8; c++) begin
            k_ready = int'($urandom_range(20, 100));
            k_ack   = int'($urandom_range(30, 100));
            k_redir = int'($urandom_range(0, 6));
            k_err   = int'($urandom_range(0, 3));
            k_lat   = int'($urandom_range(1, 5));
            run(400);
            do_reset();
        end
        k_ready = 100;
        k_ack   = 100;
        k_redir = 0;
        k_err   = 0;
        run(20);
        chk("progress", n_hs > 500, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
